// File: rtl/entropy_conditioner.sv
// Conditions an asynchronous noise bit for the prng: synchroniser, decimator, repetition-count
// health test, von Neumann pair extractor and a small bit pool drained one bit per cycle.
module entropy_conditioner #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned SAMPLE_DIV  = 4,
  parameter int unsigned POOL_BITS   = 8,
  parameter int unsigned STUCK_LIMIT = 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               raw_in_i,
  input  logic                               enable_i,
  input  logic                               stuck_clr_i,
  output logic                               entropy_o,
  output logic                               entropy_valid_o,
  output logic                               stuck_o,
  output logic [$clog2(POOL_BITS+1)-1:0]     fill_o
);

  localparam int unsigned FillW = $clog2(POOL_BITS + 1);
  localparam int unsigned DivW  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned RepW  = $clog2(STUCK_LIMIT + 1);

  typedef enum logic {StIdle = 1'b0, StFirst = 1'b1} pair_st_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DivW-1:0]        div_q, div_d;
  logic [RepW-1:0]        rep_q, rep_d;
  logic                   last_q, last_d;
  logic                   stuck_q, stuck_d;
  pair_st_e               state_q, state_d;
  logic                   first_q, first_d;
  logic [POOL_BITS-1:0]   pool_q, pool_d;
  logic [FillW-1:0]       fill_q, fill_d;

  logic sample;
  logic tick;
  logic stuck_set;
  logic push;
  logic pop;

  assign sample = sync_q[SYNC_STAGES-1];
  assign sync_d = {sync_q[SYNC_STAGES-2:0], raw_in_i};
  assign tick   = enable_i && (div_q == DivW'(SAMPLE_DIV - 1));

  always_comb begin
    div_d = div_q;
    if (enable_i) begin
      div_d = (div_q == DivW'(SAMPLE_DIV - 1)) ? '0 : div_q + DivW'(1);
    end
  end

  // Repetition test; a zero count marks the first sample after reset or clear.
  always_comb begin
    rep_d     = rep_q;
    last_d    = last_q;
    stuck_d   = stuck_q;
    stuck_set = 1'b0;
    if (tick) begin
      last_d = sample;
      if (rep_q == '0 || sample != last_q) begin
        rep_d = RepW'(1);
      end else if (rep_q != RepW'(STUCK_LIMIT)) begin
        rep_d = rep_q + RepW'(1);
      end
      stuck_set = !stuck_q && (rep_d == RepW'(STUCK_LIMIT));
      if (stuck_set) begin
        stuck_d = 1'b1;
      end
    end
    if (stuck_clr_i) begin
      stuck_d = 1'b0;
      rep_d   = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    first_d = first_q;
    push    = 1'b0;
    if (stuck_clr_i || stuck_set) begin
      state_d = StIdle;
    end else if (tick && !stuck_q) begin
      unique case (state_q)
        StIdle: begin
          state_d = StFirst;
          first_d = sample;
        end
        StFirst: begin
          state_d = StIdle;
          push    = (sample != first_q);
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Pool: oldest bit at index 0; a simultaneous push lands behind the shifted contents.
  always_comb begin
    pop    = enable_i && (fill_q != '0);
    pool_d = pool_q;
    fill_d = fill_q;
    if (pop) begin
      pool_d = pool_q >> 1;
    end
    if (push && pop) begin
      for (int unsigned i = 0; i < POOL_BITS; i++) begin
        if (FillW'(i + 1) == fill_q) begin
          pool_d[i] = first_q;
        end
      end
    end else if (push) begin
      if (fill_q != FillW'(POOL_BITS)) begin
        for (int unsigned i = 0; i < POOL_BITS; i++) begin
          if (FillW'(i) == fill_q) begin
            pool_d[i] = first_q;
          end
        end
        fill_d = fill_q + FillW'(1);
      end
    end else if (pop) begin
      fill_d = fill_q - FillW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= '0;
      div_q   <= '0;
      rep_q   <= '0;
      last_q  <= 1'b0;
      stuck_q <= 1'b0;
      state_q <= StIdle;
      first_q <= 1'b0;
      pool_q  <= '0;
      fill_q  <= '0;
    end else begin
      sync_q  <= sync_d;
      div_q   <= div_d;
      rep_q   <= rep_d;
      last_q  <= last_d;
      stuck_q <= stuck_d;
      state_q <= state_d;
      first_q <= first_d;
      pool_q  <= pool_d;
      fill_q  <= fill_d;
    end
  end

  assign entropy_o       = pop & pool_q[0];
  assign entropy_valid_o = pop;
  assign stuck_o         = stuck_q;
  assign fill_o          = fill_q;

endmodule

// File: tb/tb_entropy_conditioner.sv
// Randomised bench for entropy_conditioner, checked every cycle against a queue-based model
// plus directed checks for stuck detection, clear, freeze and mid-run reset.
module tb_entropy_conditioner;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned SAMPLE_DIV  = 4;
  localparam int unsigned POOL_BITS   = 8;
  localparam int unsigned STUCK_LIMIT = 32;
  localparam int unsigned FillW       = $clog2(POOL_BITS + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             raw_in;
  logic             enable;
  logic             stuck_clr;
  logic             entropy;
  logic             entropy_valid;
  logic             stuck;
  logic [FillW-1:0] fill;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state.
  bit sq[$];
  bit pool[$];
  int ecnt;
  int run;
  bit last;
  bit m_stuck;
  bit have_first;
  bit first;

  always #5 clk = ~clk;

  entropy_conditioner #(
    .SYNC_STAGES(SYNC_STAGES),
    .SAMPLE_DIV (SAMPLE_DIV),
    .POOL_BITS  (POOL_BITS),
    .STUCK_LIMIT(STUCK_LIMIT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .raw_in_i       (raw_in),
    .enable_i       (enable),
    .stuck_clr_i    (stuck_clr),
    .entropy_o      (entropy),
    .entropy_valid_o(entropy_valid),
    .stuck_o        (stuck),
    .fill_o         (fill)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    sq.delete();
    for (int i = 0; i < SYNC_STAGES; i++) sq.push_back(1'b0);
    pool.delete();
    ecnt       = 0;
    run        = 0;
    last       = 1'b0;
    m_stuck    = 1'b0;
    have_first = 1'b0;
    first      = 1'b0;
  endtask

  function automatic bit sets_stuck();
    return rst_n && enable && (ecnt == SAMPLE_DIV - 1) && !m_stuck && run != 0 &&
           sq[0] == last && run == STUCK_LIMIT - 1;
  endfunction

  task automatic model_edge();
    bit s, tick, pop, push, set;
    if (!rst_n) begin
      model_reset();
      return;
    end
    s    = sq[0];
    tick = enable && (ecnt == SAMPLE_DIV - 1);
    pop  = enable && pool.size() != 0;
    push = 1'b0;
    set  = 1'b0;
    if (enable) ecnt = (ecnt + 1) % SAMPLE_DIV;
    if (tick) begin
      if (run == 0 || s != last) run = 1;
      else if (run < STUCK_LIMIT) run = run + 1;
      last = s;
      set  = !m_stuck && run == STUCK_LIMIT;
    end
    if (stuck_clr) begin
      m_stuck    = 1'b0;
      run        = 0;
      have_first = 1'b0;
    end else if (tick) begin
      if (set) begin
        m_stuck    = 1'b1;
        have_first = 1'b0;
      end else if (!m_stuck) begin
        if (!have_first) begin
          first      = s;
          have_first = 1'b1;
        end else begin
          have_first = 1'b0;
          push       = (s != first);
        end
      end
    end
    if (pop) void'(pool.pop_front());
    if (push && pool.size() < POOL_BITS) pool.push_back(first);
    sq.push_back(raw_in);
    void'(sq.pop_front());
  endtask

  task automatic check_outputs();
    bit ev;
    ev = enable && pool.size() != 0;
    chk("entropy_valid", entropy_valid, ev);
    chk("entropy", entropy, ev ? pool[0] : 1'b0);
    chk("stuck", stuck, m_stuck);
    chk("fill", fill, pool.size());
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic run_rand(input int n, input int en_pct, input int clr_pct);
    for (int i = 0; i < n; i++) begin
      raw_in    = 1'($urandom_range(1));
      enable    = ($urandom_range(99) < en_pct);
      stuck_clr = ($urandom_range(99) < clr_pct);
      cycle();
    end
    stuck_clr = 1'b0;
  endtask

  initial begin
    bit found;
    rst_n     = 1'b0;
    raw_in    = 1'b0;
    enable    = 1'b0;
    stuck_clr = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    cycle();
    rst_n = 1'b1;
    chk("reset_fill", fill, 0);
    chk("reset_stuck", stuck, 0);
    chk("reset_valid", entropy_valid, 0);

    // Alternating samples: every pair differs, so the pool never backs up.
    enable = 1'b1;
    for (int i = 0; i < 96; i++) begin
      raw_in = 1'((i / SAMPLE_DIV) % 2);
      cycle();
      chk("alt_fill_le1", fill <= 1, 1);
    end

    run_rand(600, 90, 1);

    // Constant source must trip the repetition test and then stop pushes.
    stuck_clr = 1'b0;
    enable    = 1'b1;
    raw_in    = 1'b1;
    for (int i = 0; i < SAMPLE_DIV * (STUCK_LIMIT + 4) + 20; i++) cycle();
    chk("held_stuck", stuck, 1);
    chk("held_fill", fill, 0);
    stuck_clr = 1'b1;
    cycle();
    stuck_clr = 1'b0;
    chk("clr_stuck", stuck, 0);
    run_rand(200, 100, 0);

    // Freeze with a bit waiting in the pool.
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      raw_in = 1'($urandom_range(1));
      enable = 1'b1;
      cycle();
      found = (pool.size() != 0);
    end
    chk("freeze_found", found, 1);
    enable = 1'b0;
    for (int i = 0; i < 12; i++) begin
      raw_in = 1'($urandom_range(1));
      cycle();
      chk("freeze_entropy", entropy, 0);
    end
    chk("freeze_fill", fill, 1);
    run_rand(100, 100, 0);

    // Mid-run reset.
    run_rand(50, 80, 0);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("rst_mid_fill", fill, 0);
    chk("rst_mid_stuck", stuck, 0);
    run_rand(150, 90, 0);

    // Clear on the very tick that would set stuck: clear wins.
    enable = 1'b1;
    raw_in = 1'b1;
    found  = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      stuck_clr = sets_stuck();
      found     = stuck_clr;
      cycle();
    end
    stuck_clr = 1'b0;
    chk("clr_race_found", found, 1);
    chk("clr_race_stuck", stuck, 0);
    for (int i = 0; i < 60; i++) cycle();
    chk("clr_race_hold", stuck, 0);
    run_rand(200, 90, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
